// File: rtl/vram_text_pkg.sv
// Shared constants, state encoding and address helper for the text-console VRAM writer.
package vram_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 11;
  localparam int CELLS  = COLS * ROWS;

  // Cell layout: [10:8] foreground RGB, [7] zero, [6:0] ASCII.
  localparam logic [DATA_W-1:0] BLANK = 11'h020;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;

  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS_A       = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0] COPY_CELLS    = ADDR_W'(CELLS - COLS);
  localparam logic [ADDR_W-1:0] LAST_COPY     = ADDR_W'(CELLS - COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(CELLS - COLS);
  localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW      = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SCROLL,
    ST_BLANK_ROW
  } state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return ADDR_W'(row) * COLS_A + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vram_seq_engine.sv
// Address sequencer for bulk VRAM operations: clear, scroll copy (read k+80 -> write k)
// and last-row blanking. Emits a combinational write request that the top registers.
module vram_seq_engine
  import vram_text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_scroll,
  input  logic              i_blank_row,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_rd_valid;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              w_issue;
  logic              w_run;

  assign w_run   = i_clear | i_scroll | i_blank_row;
  assign w_issue = i_scroll & (r_cnt < COPY_CELLS);
  assign o_raddr = r_raddr;

  // i_start preloads the first read address so it is on the port in the first SCROLL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_raddr    <= '0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_rd_valid <= i_start | w_issue;
      r_wr_valid <= r_rd_valid;
      r_wr_addr  <= r_raddr - COLS_A;
      if (i_start)
        r_raddr <= COLS_A;
      else if (w_issue)
        r_raddr <= r_cnt + COLS_A;
      if (i_start)
        r_cnt <= ADDR_W'(1);
      else if (o_done || !w_run)
        r_cnt <= '0;
      else if (i_clear || i_blank_row || w_issue)
        r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  // CLEAR and BLANK_ROW spend one extra cycle after their last write so it drains before IDLE.
  always_comb begin
    o_we    = 1'b0;
    o_waddr = r_cnt;
    o_wdata = BLANK;
    o_done  = 1'b0;
    if (i_clear) begin
      o_we   = (r_cnt != CELLS_A);
      o_done = (r_cnt == CELLS_A);
    end else if (i_blank_row) begin
      o_we    = (r_cnt != COLS_A);
      o_waddr = LAST_ROW_BASE + r_cnt;
      o_done  = (r_cnt == COLS_A);
    end else if (i_scroll) begin
      o_we    = r_wr_valid;
      o_waddr = r_wr_addr;
      o_wdata = i_rdata;
      o_done  = r_wr_valid && (r_wr_addr == LAST_COPY);
    end
  end

endmodule

// File: rtl/vram_text_writer.sv
// Text-console front end: accepts characters, tracks the cursor and drives the VRAM write
// port, delegating clear/scroll/blank-row sequences to vram_seq_engine.
module vram_text_writer
  import vram_text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  input  logic [2:0]        char_attr,
  output logic              char_ready,
  input  logic              clr_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [5:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              busy
);

  state_e            r_state;
  state_e            w_next_state;
  logic [5:0]        r_row;
  logic [6:0]        r_col;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic [5:0]        w_next_row;
  logic [6:0]        w_next_col;
  logic              w_new_line;
  logic              w_scroll;

  logic              w_eng_we;
  logic [ADDR_W-1:0] w_eng_waddr;
  logic [DATA_W-1:0] w_eng_wdata;
  logic              w_eng_done;

  assign char_ready = (r_state == ST_IDLE) & ~clr_req;
  assign w_accept   = char_valid & char_ready;
  assign busy       = (r_state != ST_IDLE);
  assign vram_we    = r_we;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

  vram_seq_engine u_engine (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (r_state == ST_CLEAR),
    .i_scroll    (r_state == ST_SCROLL),
    .i_blank_row (r_state == ST_BLANK_ROW),
    .i_start     (w_scroll),
    .i_rdata     (vram_rdata),
    .o_raddr     (vram_raddr),
    .o_we        (w_eng_we),
    .o_waddr     (w_eng_waddr),
    .o_wdata     (w_eng_wdata),
    .o_done      (w_eng_done)
  );

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_acc_we   = 1'b0;
    w_acc_addr = cell_addr(r_row, r_col);
    w_acc_data = BLANK;
    w_next_row = r_row;
    w_next_col = r_col;
    w_new_line = 1'b0;
    if (w_accept) begin
      if (char_data >= SPACE && char_data <= TILDE) begin
        w_acc_we   = 1'b1;
        w_acc_data = {char_attr, 1'b0, char_data[6:0]};
        if (r_col == LAST_COL) begin
          w_next_col = '0;
          w_new_line = 1'b1;
        end else begin
          w_next_col = r_col + 7'd1;
        end
      end else if (char_data == LF) begin
        w_next_col = '0;
        w_new_line = 1'b1;
      end else if (char_data == CR) begin
        w_next_col = '0;
      end else if (char_data == BS && r_col != '0) begin
        w_next_col = r_col - 7'd1;
        w_acc_we   = 1'b1;
        w_acc_addr = cell_addr(r_row, r_col - 7'd1);
      end
    end
    if (w_new_line && r_row != LAST_ROW)
      w_next_row = r_row + 6'd1;
  end

  // The bottom row stays put on a new line; the screen contents move instead.
  assign w_scroll = w_new_line & (r_row == LAST_ROW);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CLEAR:     if (w_eng_done) w_next_state = ST_IDLE;
      ST_IDLE: begin
        if (clr_req)       w_next_state = ST_CLEAR;
        else if (w_scroll) w_next_state = ST_SCROLL;
      end
      ST_SCROLL:    if (w_eng_done) w_next_state = ST_BLANK_ROW;
      ST_BLANK_ROW: if (w_eng_done) w_next_state = ST_IDLE;
      default:      w_next_state = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_CLEAR;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == ST_CLEAR && w_eng_done) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_next_row;
      r_col <= w_next_col;
    end
  end

  // Engine and accept writes are mutually exclusive: accepts only happen in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= BLANK;
    end else begin
      r_we <= w_eng_we | w_acc_we;
      if (w_eng_we) begin
        r_waddr <= w_eng_waddr;
        r_wdata <= w_eng_wdata;
      end else if (w_acc_we) begin
        r_waddr <= w_acc_addr;
        r_wdata <= w_acc_data;
      end
    end
  end

endmodule
